// File: rtl/cpu_clock_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_clock_ctrl
//
// Purpose:
//   Sequences and arbitrates changes to the CPU clock divider setting.
//   Two requesters compete for the divider: the host register interface and
//   the thermal/power throttle logic. The throttle wins when both ask in the
//   same cycle. After a new divisor is applied, the block waits for the
//   divider output to toggle SETTLE_TOGGLES times at the new rate before it
//   acknowledges. If the divider stays silent for TIMEOUT cycles, the block
//   sets a sticky error and acknowledges anyway. The new divisor is kept.
//
// Optional feature (compile-time macro CLKCTRL_THROTTLE_FLOOR_EN):
//   When the macro is defined, each completed throttle request records its
//   divisor as a floor. Host targets below the floor are raised to it.
//   A throttle divisor of 0 clears the floor. Throttle targets are never
//   clamped. When the macro is undefined, there is no floor register.
//
// Parameters:
//   DEFAULT_DIV     divisor driven after reset
//   SETTLE_TOGGLES  divider-output toggles needed before acknowledging (1..3)
//   TIMEOUT         maximum cycles spent in SETTLE (8-bit, >= 100)
//
// Ports:
//   CLK         system clock; also clocks the divider
//   RST         synchronous active-high reset
//   HOST_REQ    host change request (level, held until HOST_ACK)
//   HOST_DIV    requested host divisor
//   HOST_ACK    one-cycle completion pulse to host
//   THR_REQ     throttle change request (level, held until THR_ACK)
//   THR_DIV     throttle divisor
//   THR_ACK     one-cycle completion pulse to throttle
//   DIV_OUT     divisor driven to the clock divider
//   DIV_CLK_IN  divider output, sampled in the CLK domain
//   BUSY        high whenever the FSM is not idle
//   CUR_SRC     owner of the last accepted request (0 host, 1 throttle)
//   ERR         sticky settle-timeout flag, cleared on the next accept
// ---------------------------------------------------------------------------
module cpu_clock_ctrl #(
  parameter logic [4:0] DEFAULT_DIV    = 5'd3,
  parameter int         SETTLE_TOGGLES = 2,
  parameter int         TIMEOUT        = 127
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       HOST_REQ,
  input  logic [4:0] HOST_DIV,
  output logic       HOST_ACK,
  input  logic       THR_REQ,
  input  logic [4:0] THR_DIV,
  output logic       THR_ACK,
  output logic [4:0] DIV_OUT,
  input  logic       DIV_CLK_IN,
  output logic       BUSY,
  output logic       CUR_SRC,
  output logic       ERR
);

  localparam logic [2:0] SETTLE_LIMIT  = 3'(SETTLE_TOGGLES);
  localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [4:0] target;
  logic [4:0] target_next;
  logic [4:0] div_next;
  logic       src_next;
  logic       err_next;
  logic [1:0] tog_cnt;
  logic [1:0] tog_next;
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_next;
  logic       div_clk_q;
  logic       toggle;
  logic [2:0] tog_inc;
  logic [8:0] tmo_inc;
  logic       busy_next;
  logic       host_ack_next;
  logic       thr_ack_next;

`ifdef CLKCTRL_THROTTLE_FLOOR_EN
  logic [4:0] floor_div;
  logic [4:0] floor_next;

  // Raise a host divisor to the throttle floor when it would run faster.
  function automatic logic [4:0] clamp_to_floor(input logic [4:0] req,
                                                input logic [4:0] flr);
    logic [4:0] res;
    if (req < flr) begin
      res = flr;
    end else begin
      res = req;
    end
    return res;
  endfunction
`endif

  // A toggle is any cycle in which the divider output differs from the
  // value it had in the previous cycle.
  assign toggle  = DIV_CLK_IN ^ div_clk_q;
  // The incremented counters are one bit wider so that a compare never wraps.
  assign tog_inc = {1'b0, tog_cnt} + 3'd1;
  assign tmo_inc = {1'b0, tmo_cnt} + 9'd1;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_next  = state;
    target_next = target;
    div_next    = DIV_OUT;
    src_next    = CUR_SRC;
    err_next    = ERR;
    tog_next    = tog_cnt;
    tmo_next    = tmo_cnt;
`ifdef CLKCTRL_THROTTLE_FLOOR_EN
    floor_next  = floor_div;
`endif

    case (state)
      IDLE: begin
        if (THR_REQ) begin
          target_next = THR_DIV;
          src_next    = 1'b1;
          err_next    = 1'b0;
          state_next  = APPLY;
        end else if (HOST_REQ) begin
`ifdef CLKCTRL_THROTTLE_FLOOR_EN
          target_next = clamp_to_floor(HOST_DIV, floor_div);
`else
          target_next = HOST_DIV;
`endif
          src_next    = 1'b0;
          err_next    = 1'b0;
          state_next  = APPLY;
        end else begin
          state_next  = IDLE;
        end
      end

      APPLY: begin
        div_next = target;
        tog_next = 2'd0;
        tmo_next = 8'd0;
        // If the divisor does not change, there is no new rate to confirm.
        if (target == DIV_OUT) begin
          state_next = DONE;
        end else begin
          state_next = SETTLE;
        end
      end

      SETTLE: begin
        tmo_next = tmo_inc[7:0];
        if (toggle) begin
          tog_next = tog_inc[1:0];
        end else begin
          tog_next = tog_cnt;
        end
        // A toggle that completes the count beats a timeout in the same cycle.
        if (toggle && (tog_inc == SETTLE_LIMIT)) begin
          state_next = DONE;
        end else if (tmo_inc >= TIMEOUT_LIMIT) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          state_next = SETTLE;
        end
      end

      DONE: begin
        state_next = IDLE;
`ifdef CLKCTRL_THROTTLE_FLOOR_EN
        // A completed throttle request sets the floor. A divisor of 0 clears it.
        if (CUR_SRC) begin
          floor_next = target;
        end else begin
          floor_next = floor_div;
        end
`endif
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // The outputs are registered, so they are decoded from the state being entered.
    busy_next     = (state_next != IDLE);
    host_ack_next = (state_next == DONE) && !src_next;
    thr_ack_next  = (state_next == DONE) &&  src_next;
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      target    <= DEFAULT_DIV;
      DIV_OUT   <= DEFAULT_DIV;
      CUR_SRC   <= 1'b0;
      ERR       <= 1'b0;
      BUSY      <= 1'b0;
      HOST_ACK  <= 1'b0;
      THR_ACK   <= 1'b0;
      tog_cnt   <= 2'd0;
      tmo_cnt   <= 8'd0;
      div_clk_q <= 1'b0;
    end else begin
      state     <= state_next;
      target    <= target_next;
      DIV_OUT   <= div_next;
      CUR_SRC   <= src_next;
      ERR       <= err_next;
      BUSY      <= busy_next;
      HOST_ACK  <= host_ack_next;
      THR_ACK   <= thr_ack_next;
      tog_cnt   <= tog_next;
      tmo_cnt   <= tmo_next;
      div_clk_q <= DIV_CLK_IN;
    end
  end

`ifdef CLKCTRL_THROTTLE_FLOOR_EN
  // Throttle floor register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      floor_div <= 5'd0;
    end else begin
      floor_div <= floor_next;
    end
  end
`endif

endmodule

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

Controller that sequences and arbitrates changes to the CPU clock divider setting in the South Bridge. Two requesters compete for the divider: the host register interface and the thermal/power throttle logic. The block owns the divider's DIV input and applies a new divisor, then confirms that the divider has run at the new rate before acknowledging. It sits between the register/throttle logic and the CPU clock divider, in the same CLK domain.

## Interface

Parameters:
- DEFAULT_DIV, 5'd3: divisor driven after reset.
- SETTLE_TOGGLES, 2: divider-output toggles to observe after a change before acknowledging (1..3).
- TIMEOUT, 127: maximum cycles spent in SETTLE before aborting with error (8-bit, ≥ 100).

Ports:
- CLK  in  1  system clock; also clocks the divider.
- RST  in  1  reset: synchronous, active-high.
- HOST_REQ  in  1  host change request; level, held until HOST_ACK.
- HOST_DIV  in  5  requested divisor; stable while HOST_REQ is high.
- HOST_ACK  out  1  one-cycle completion pulse to host.
- THR_REQ  in  1  throttle change request; level, held until THR_ACK.
- THR_DIV  in  5  throttle divisor; stable while THR_REQ is high.
- THR_ACK  out  1  one-cycle completion pulse to throttle.
- DIV_OUT  out  5  divisor to the clock divider's DIV input.
- DIV_CLK_IN  in  1  divider output, sampled in the CLK domain.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- CUR_SRC  out  1  owner of the last accepted request: 0 = host, 1 = throttle.
- ERR  out  1  sticky settle-timeout flag.

## Operation

- FSM states: IDLE, APPLY, SETTLE, DONE.
- IDLE:
  - If THR_REQ is high, accept the throttle request. THR_REQ has priority when both requests are high in the same cycle.
  - Otherwise, if HOST_REQ is high, accept the host request.
  - On accept: latch the target divisor and source into CUR_SRC, clear ERR, and go to APPLY.
- APPLY (1 cycle):
  - Register DIV_OUT <= target. Clear the toggle counter and the timeout counter.
  - If the target equals the old DIV_OUT, go directly to DONE. Otherwise go to SETTLE.
- SETTLE:
  - Toggle detection uses a 1-bit registered copy of DIV_CLK_IN. A toggle is any cycle where DIV_CLK_IN differs from that registered copy.
  - Count toggles. When the count reaches SETTLE_TOGGLES, go to DONE.
  - The timeout counter increments every SETTLE cycle. If it reaches TIMEOUT first, set ERR and go to DONE. DIV_OUT keeps the new value.
  - If a toggle and the timeout occur in the same cycle, the toggle wins: ERR is not set if that toggle completes the count.
- DONE (1 cycle): the ACK of the latched source is high for this cycle only. Then return to IDLE.
- Requests that arrive while BUSY are not lost. They are sampled again in IDLE.
- A requester must drop REQ in the cycle after its ACK. A REQ still high in that IDLE cycle is treated as a new request.
- Divisor arithmetic:
  - 5-bit unsigned, no wrap.
  - The divider half-period is DIV+1 CLK cycles.
  - The worst case settle at DIV=31 with SETTLE_TOGGLES=2 is under 100 cycles. A healthy divider therefore never trips TIMEOUT=127.

## Timing

- Reset values: DIV_OUT = DEFAULT_DIV; HOST_ACK, THR_ACK, BUSY, CUR_SRC, ERR = 0; state IDLE; toggle copy = 0; throttle floor = 0.
- Cycle 0: REQ sampled in IDLE.
- Cycle 1: APPLY, with BUSY high.
- Cycle 2: DIV_OUT holds the new value.
- Same-value request: ACK in cycle 2, so REQ-to-ACK latency is 2.
- Changed value: ACK in the cycle after the SETTLE_TOGGLES-th toggle is detected, or in cycle TIMEOUT+2 on timeout.
- RST asserted mid-operation: the transaction is aborted with no ACK, and all outputs return to reset values on the next edge, including DIV_OUT = DEFAULT_DIV.
- All outputs are registered.

## Configuration

- CLKCTRL_THROTTLE_FLOOR_EN defined:
  - Each completed throttle request stores THR_DIV as a floor; THR_DIV = 0 clears it.
  - An accepted host target below the floor is clamped up to the floor.
  - Throttle targets are never clamped.
- CLKCTRL_THROTTLE_FLOOR_EN undefined:
  - No floor register. Host targets are applied unmodified.
  - Arbitration and priority are unchanged.

## Test plan

- Same-value request: reset, then HOST_REQ with HOST_DIV=3 → HOST_ACK 2 cycles later, no settle, DIV_OUT stays 3, ERR=0.
- Change to a new divisor: HOST_DIV=7 with a live divider → DIV_OUT=7 in cycle 2; HOST_ACK one cycle after the 2nd DIV_CLK_IN toggle; CUR_SRC=0.
- Simultaneous requests: HOST_REQ(DIV=5) and THR_REQ(DIV=15) in the same cycle → throttle served first (THR_ACK, CUR_SRC=1, DIV_OUT=15); host then served (HOST_ACK, DIV_OUT=5).
- Timeout: hold DIV_CLK_IN constant, then request DIV=9 → ERR=1 and ACK at cycle 129, DIV_OUT=9; the next accepted request clears ERR.
- Reset mid-operation: assert RST during SETTLE → no ACK, DIV_OUT=3, BUSY=0 on the next edge.
- With CLKCTRL_THROTTLE_FLOOR_EN: throttle sets floor 12, then HOST_DIV=4 → DIV_OUT=12. After a throttle request with DIV=0, HOST_DIV=4 → DIV_OUT=4.
